// File: rtl/ps2_rx_fifo_if.sv
// Consumer-side handshake bundle for the PS/2 receive FIFO.
// The receiver drives the head byte and status; the consumer drives the pop request.
interface ps2_rx_fifo_if;
  logic [7:0] data;
  logic       ready;
  logic       nextdata_n;
  logic       overflow;
  logic       frame_err;

  modport master (
    output data,
    output ready,
    output overflow,
    output frame_err,
    input  nextdata_n
  );

  modport slave (
    input  data,
    input  ready,
    input  overflow,
    input  frame_err,
    output nextdata_n
  );
endinterface

// File: rtl/ps2_rx_fifo.sv
// PS/2 device-frame receiver with a small show-ahead byte FIFO.
// Synchronizes ps2_clk/ps2_data, checks start/parity/stop and a mid-frame
// idle timeout, then buffers good bytes for the scan-code consumer.
module ps2_rx_fifo #(
  parameter int          DEPTH_LOG2 = 3,
  parameter logic [15:0] TIMEOUT    = 16'd50000
) (
  input  logic          clk,
  input  logic          clrn,
  input  logic          ps2_clk,
  input  logic          ps2_data,
  ps2_rx_fifo_if.master bus
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] PTR_ONE = {{DEPTH_LOG2{1'b0}}, 1'b1};

  // Synchronizer stages
  logic [2:0] r_ps2c_s;
  logic [1:0] r_ps2d_s;

  // Frame receiver state
  logic [3:0]  r_cnt;
  logic [9:0]  r_shift;
  logic [15:0] r_tmo;
  logic        r_ferr;

  // FIFO state
  logic [7:0]          r_mem [DEPTH];
  logic [DEPTH_LOG2:0] r_wptr;
  logic [DEPTH_LOG2:0] r_rptr;
  logic                r_ovf;

  logic w_fall;
  logic w_bit;
  logic w_last;
  logic w_frame_ok;
  logic w_good;
  logic w_bad;
  logic w_tmo;
  logic w_empty;
  logic w_full;
  logic w_pop;
  logic w_push;

  // Bring the asynchronous PS/2 lines into the clk domain (idle level is 1)
  always_ff @(posedge clk) begin
    if (clrn) begin
      r_ps2c_s <= 3'b111;
      r_ps2d_s <= 2'b11;
    end else begin
      r_ps2c_s <= {r_ps2c_s[1:0], ps2_clk};
      r_ps2d_s <= {r_ps2d_s[0], ps2_data};
    end
  end

  assign w_fall = r_ps2c_s[2] & ~r_ps2c_s[1];
  assign w_bit  = r_ps2d_s[1];
  assign w_last = w_fall & (r_cnt == 4'd10);

  // r_shift holds start in [0], data in [8:1], parity in [9]; the stop bit is
  // the live sample on the 11th edge. Data plus parity must have odd weight.
  assign w_frame_ok = ~r_shift[0] & (^r_shift[9:1]) & w_bit;
  assign w_good     = w_last & w_frame_ok;
  assign w_bad      = w_last & ~w_frame_ok;
  assign w_tmo      = (r_cnt != 4'd0) & ~w_fall & (r_tmo == (TIMEOUT - 16'd1));

  // Count bits, shift them in LSB first, and abandon stalled partial frames
  always_ff @(posedge clk) begin
    if (clrn) begin
      r_cnt   <= 4'd0;
      r_shift <= 10'd0;
      r_tmo   <= 16'd0;
      r_ferr  <= 1'b0;
    end else begin
      r_ferr <= w_bad | w_tmo;
      if (w_fall) begin
        r_tmo <= 16'd0;
        if (r_cnt == 4'd10) begin
          r_cnt <= 4'd0;
        end else begin
          r_cnt   <= r_cnt + 4'd1;
          r_shift <= {w_bit, r_shift[9:1]};
        end
      end else if (r_cnt == 4'd0) begin
        r_tmo <= 16'd0;
      end else if (w_tmo) begin
        r_cnt <= 4'd0;
        r_tmo <= 16'd0;
      end else begin
        r_tmo <= r_tmo + 16'd1;
      end
    end
  end

  // Extra pointer MSB distinguishes full from empty when the low bits match
  assign w_empty = (r_wptr == r_rptr);
  assign w_full  = (r_wptr[DEPTH_LOG2] != r_rptr[DEPTH_LOG2]) &&
                   (r_wptr[DEPTH_LOG2-1:0] == r_rptr[DEPTH_LOG2-1:0]);
  assign w_pop   = ~w_empty & ~bus.nextdata_n;
  // A pop in the same cycle frees the slot, so a full FIFO can still accept
  assign w_push  = w_good & (~w_full | w_pop);

  // Store good bytes, advance pointers, and track dropped bytes until the next pop
  always_ff @(posedge clk) begin
    if (clrn) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_ovf  <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= 8'h00;
      end
    end else begin
      if (w_push) begin
        r_mem[r_wptr[DEPTH_LOG2-1:0]] <= r_shift[8:1];
        r_wptr <= r_wptr + PTR_ONE;
      end
      if (w_pop) begin
        r_rptr <= r_rptr + PTR_ONE;
        r_ovf  <= 1'b0;
      end else if (w_good & w_full) begin
        r_ovf <= 1'b1;
      end
    end
  end

  assign bus.data      = r_mem[r_rptr[DEPTH_LOG2-1:0]];
  assign bus.ready     = ~w_empty;
  assign bus.overflow  = r_ovf;
  assign bus.frame_err = r_ferr;

endmodule
